edge_detect_multi: RTL and testbench

//  Multi-channel synchronising, glitch-filtered edge detector for USB/serial line inputs.
//  Per channel: synchroniser, stability filter, rise/fall detect, mode-gated event pulse,

---
 rtl/edge_detect_multi.sv | 137 +++++++++++++
 tb/tb_edge_detect_multi.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronising, glitch-filtered edge detector. Each channel runs a
// sync chain, a stability filter, rise/fall detection, gated pulse, sticky flag and counter.
module edge_detect_multi #(
   parameter int   NUM_CH      = 4,
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CYC    = 3,
   parameter int   CNT_W       = 8,
   parameter logic RESET_LVL   = 1'b1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NUM_CH-1:0]       din,
   input  logic                    en,
   input  logic [2*NUM_CH-1:0]     mode,
   input  logic [NUM_CH-1:0]       clr_sticky,
   input  logic [NUM_CH-1:0]       clr_cnt,
   output logic [NUM_CH-1:0]       level,
   output logic [NUM_CH-1:0]       rise,
   output logic [NUM_CH-1:0]       fall,
   output logic [NUM_CH-1:0]       edge_pulse,
   output logic [NUM_CH-1:0]       sticky,
   output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

   localparam int              FC_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      ST_STABLE,
      ST_PENDING
   } filt_state_e;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic                   s;
      filt_state_e            state_q, state_d;
      logic [FC_W-1:0]        fc_q, fc_d;
      logic                   accept;
      logic                   level_q, level_d;
      logic                   rise_q, rise_d;
      logic                   fall_q, fall_d;
      logic                   pulse;
      logic                   sticky_q, sticky_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;

      always_comb begin
         sync_d[0] = din[i];
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            sync_q   <= {SYNC_STAGES{RESET_LVL}};
            state_q  <= ST_STABLE;
            fc_q     <= '0;
            level_q  <= RESET_LVL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
         end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            fc_q     <= fc_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
         end
      end

      // A new level is only taken once it has been seen FILT_CYC samples in a row.
      always_comb begin
         state_d = state_q;
         fc_d    = fc_q;
         accept  = 1'b0;
         case (state_q)
            ST_STABLE: begin
               fc_d = '0;
               if (s != level_q) begin
                  if (FILT_CYC == 1) begin
                     accept = 1'b1;
                  end else begin
                     state_d = ST_PENDING;
                     fc_d    = FC_W'(1);
                  end
               end
            end
            ST_PENDING: begin
               if (s == level_q) begin
                  state_d = ST_STABLE;
                  fc_d    = '0;
               end else if (fc_q == FC_LAST) begin
                  accept  = 1'b1;
                  state_d = ST_STABLE;
                  fc_d    = '0;
               end else begin
                  fc_d = fc_q + FC_W'(1);
               end
            end
            default: begin
               state_d = ST_STABLE;
               fc_d    = '0;
            end
         endcase
      end

      assign pulse = en & ((mode[2*i] & rise_q) | (mode[2*i+1] & fall_q));

      always_comb begin
         level_d  = accept ? s : level_q;
         rise_d   = accept & s;
         fall_d   = accept & ~s;
         sticky_d = pulse | (sticky_q & ~clr_sticky[i]);
         cnt_d    = cnt_q;
         if (clr_cnt[i]) begin
            cnt_d = pulse ? CNT_W'(1) : '0;
         end else if (pulse && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      assign level[i]                     = level_q;
      assign rise[i]                      = rise_q;
      assign fall[i]                      = fall_q;
      assign edge_pulse[i]                = pulse;
      assign sticky[i]                    = sticky_q;
      assign edge_cnt[CNT_W*i +: CNT_W]   = cnt_q;
   end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: a per-step vector table on the default
// configuration plus sequences for saturation, clears, reset and a fast configuration.
module tb_edge_detect_multi;

   logic        clk;
   logic        n_rst;
   logic [3:0]  din;
   logic [3:0]  din_f;
   logic        en;
   logic [7:0]  mode;
   logic [3:0]  clr_sticky;
   logic [3:0]  clr_cnt;

   logic [3:0]  level, rise, fall, edge_pulse, sticky;
   logic [31:0] edge_cnt;
   logic [3:0]  level_f, rise_f, fall_f, pulse_f, sticky_f;
   logic [31:0] cnt_f;

   int compared;
   int mismatched;

   typedef struct {
      logic [3:0]  din;
      logic        en;
      logic [3:0]  clr_s;
      logic [3:0]  clr_c;
      int          cyc;
      logic [3:0]  lvl;
      logic [3:0]  r;
      logic [3:0]  f;
      logic [3:0]  p;
      logic [3:0]  s;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[22];

   edge_detect_multi dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .din        (din),
      .en         (en),
      .mode       (mode),
      .clr_sticky (clr_sticky),
      .clr_cnt    (clr_cnt),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .edge_pulse (edge_pulse),
      .sticky     (sticky),
      .edge_cnt   (edge_cnt)
   );

   edge_detect_multi #(.SYNC_STAGES(1), .FILT_CYC(1)) dut_fast (
      .clk        (clk),
      .n_rst      (n_rst),
      .din        (din_f),
      .en         (en),
      .mode       (mode),
      .clr_sticky (clr_sticky),
      .clr_cnt    (clr_cnt),
      .level      (level_f),
      .rise       (rise_f),
      .fall       (fall_f),
      .edge_pulse (pulse_f),
      .sticky     (sticky_f),
      .edge_cnt   (cnt_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] d, input logic e, input logic [3:0] cs,
                               input logic [3:0] cc, input int n, input logic [3:0] lv,
                               input logic [3:0] r, input logic [3:0] f, input logic [3:0] p,
                               input logic [3:0] s, input logic [31:0] c);
      vec_t v;
      v.din = d; v.en = e; v.clr_s = cs; v.clr_c = cc; v.cyc = n;
      v.lvl = lv; v.r = r; v.f = f; v.p = p; v.s = s; v.cnt = c;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Drives one vector's inputs, runs its clock count, then samples 1ns after the edge.
   task automatic applyStimulus(input vec_t v);
      din        = v.din;
      en         = v.en;
      clr_sticky = v.clr_s;
      clr_cnt    = v.clr_c;
      repeat (v.cyc) @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen;
      compared   = 0;
      mismatched = 0;
      n_rst      = 1'b0;
      din        = 4'hF;
      din_f      = 4'hF;
      en         = 1'b1;
      mode       = 8'hDE;
      clr_sticky = 4'h0;
      clr_cnt    = 4'h0;

      vecs[0]  = mk(4'hF, 1, 0, 0, 3, 4'hF, 0, 0, 0, 0, 32'h0);
      vecs[1]  = mk(4'hE, 1, 0, 0, 4, 4'hF, 0, 0, 0, 0, 32'h0);
      vecs[2]  = mk(4'hE, 1, 0, 0, 1, 4'hE, 0, 1, 1, 0, 32'h0);
      vecs[3]  = mk(4'hE, 1, 0, 0, 1, 4'hE, 0, 0, 0, 1, 32'h1);
      vecs[4]  = mk(4'hC, 1, 0, 0, 2, 4'hE, 0, 0, 0, 1, 32'h1);
      vecs[5]  = mk(4'hE, 1, 0, 0, 6, 4'hE, 0, 0, 0, 1, 32'h1);
      vecs[6]  = mk(4'hC, 1, 0, 0, 3, 4'hE, 0, 0, 0, 1, 32'h1);
      vecs[7]  = mk(4'hE, 1, 0, 0, 1, 4'hE, 0, 0, 0, 1, 32'h1);
      vecs[8]  = mk(4'hE, 1, 0, 0, 1, 4'hC, 0, 2, 2, 1, 32'h1);
      vecs[9]  = mk(4'hE, 1, 0, 0, 2, 4'hC, 0, 0, 0, 3, 32'h101);
      vecs[10] = mk(4'hE, 1, 0, 0, 1, 4'hE, 2, 0, 2, 3, 32'h101);
      vecs[11] = mk(4'hE, 1, 0, 0, 1, 4'hE, 0, 0, 0, 3, 32'h201);
      vecs[12] = mk(4'hA, 1, 0, 0, 4, 4'hE, 0, 0, 0, 3, 32'h201);
      vecs[13] = mk(4'hA, 1, 0, 0, 1, 4'hA, 0, 4, 0, 3, 32'h201);
      vecs[14] = mk(4'hA, 1, 0, 0, 1, 4'hA, 0, 0, 0, 3, 32'h201);
      vecs[15] = mk(4'hE, 1, 0, 0, 5, 4'hE, 4, 0, 4, 3, 32'h201);
      vecs[16] = mk(4'hE, 1, 0, 0, 1, 4'hE, 0, 0, 0, 7, 32'h10201);
      vecs[17] = mk(4'hA, 0, 0, 0, 5, 4'hA, 0, 4, 0, 7, 32'h10201);
      vecs[18] = mk(4'hE, 0, 0, 0, 5, 4'hE, 4, 0, 0, 7, 32'h10201);
      vecs[19] = mk(4'hE, 0, 0, 0, 1, 4'hE, 0, 0, 0, 7, 32'h10201);
      vecs[20] = mk(4'hE, 1, 1, 1, 1, 4'hE, 0, 0, 0, 6, 32'h10200);
      vecs[21] = mk(4'hE, 1, 0, 0, 1, 4'hE, 0, 0, 0, 6, 32'h10200);

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset level", 32'(level), 32'hF);
      checkOutput("reset sticky", 32'(sticky), 32'h0);
      checkOutput("reset cnt", edge_cnt, 32'h0);
      n_rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].lvl));
         checkOutput($sformatf("v%0d rise", i), 32'(rise), 32'(vecs[i].r));
         checkOutput($sformatf("v%0d fall", i), 32'(fall), 32'(vecs[i].f));
         checkOutput($sformatf("v%0d edge_pulse", i), 32'(edge_pulse), 32'(vecs[i].p));
         checkOutput($sformatf("v%0d sticky", i), 32'(sticky), 32'(vecs[i].s));
         checkOutput($sformatf("v%0d edge_cnt", i), edge_cnt, vecs[i].cnt);
      end
      clr_sticky = 4'h0;
      clr_cnt    = 4'h0;

      // 260 accepted edges on ch3 must pin its counter at 255.
      for (int k = 0; k < 260; k++) begin
         din[3] = ~din[3];
         repeat (4) @(posedge clk);
      end
      repeat (8) @(posedge clk);
      #1;
      checkOutput("sat cnt3", 32'(edge_cnt[31:24]), 32'hFF);
      checkOutput("sat other cnts", 32'(edge_cnt[23:0]), 32'h010200);
      checkOutput("sat sticky", 32'(sticky), 32'hE);
      checkOutput("sat level", 32'(level), 32'hE);

      din = 4'h6;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("ch3 fall pulse", 32'(edge_pulse), 32'h8);
      checkOutput("ch3 cnt held", 32'(edge_cnt[31:24]), 32'hFF);
      clr_cnt    = 4'h8;
      clr_sticky = 4'h8;
      @(posedge clk);
      #1;
      checkOutput("clr_cnt with pulse", 32'(edge_cnt[31:24]), 32'h1);
      checkOutput("clr_sticky with pulse", 32'(sticky[3]), 32'h1);
      clr_cnt = 4'h0;
      @(posedge clk);
      #1;
      checkOutput("clr_sticky alone", 32'(sticky), 32'h6);
      clr_sticky = 4'h0;

      #3;
      n_rst = 1'b0;
      #1;
      checkOutput("async reset level", 32'(level), 32'hF);
      checkOutput("async reset rise", 32'(rise), 32'h0);
      checkOutput("async reset fall", 32'(fall), 32'h0);
      checkOutput("async reset pulse", 32'(edge_pulse), 32'h0);
      checkOutput("async reset sticky", 32'(sticky), 32'h0);
      checkOutput("async reset cnt", edge_cnt, 32'h0);
      din   = 4'hF;
      din_f = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      // Reset while ch0 is mid-filter must discard the pending change.
      din = 4'hE;
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      checkOutput("pending reset level", 32'(level), 32'hF);
      din = 4'hF;
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      seen  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         seen = seen | fall[0] | edge_pulse[0];
      end
      checkOutput("pending reset no pulse", 32'(seen), 32'h0);
      checkOutput("pending reset level after", 32'(level), 32'hF);
      checkOutput("pending reset cnt", edge_cnt, 32'h0);

      din_f = 4'hE;
      @(posedge clk);
      #1;
      checkOutput("fast level e1", 32'(level_f), 32'hF);
      @(posedge clk);
      #1;
      checkOutput("fast level e2", 32'(level_f), 32'hE);
      checkOutput("fast fall e2", 32'(fall_f), 32'h1);
      checkOutput("fast pulse e2", 32'(pulse_f), 32'h1);
      din_f = 4'hF;
      @(posedge clk);
      #1;
      checkOutput("fast level r1", 32'(level_f), 32'hE);
      checkOutput("fast fall cleared", 32'(fall_f), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("fast level r2", 32'(level_f), 32'hF);
      checkOutput("fast rise r2", 32'(rise_f), 32'h1);
      checkOutput("fast pulse r2", 32'(pulse_f), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("fast rise cleared", 32'(rise_f), 32'h0);
      checkOutput("fast sticky", 32'(sticky_f), 32'h1);
      checkOutput("fast cnt", cnt_f, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
